// File: rtl/popcount_seq_if.sv
// popcount_seq_if: request/response bundle for popcount_seq.
//   Request side : in_valid_i / in_ready_o / data_i
//   Response side: out_valid_o / out_ready_i / count_o
//   Status       : busy_o
// Optional macro POPCOUNT_SEQ_THRESH_EN adds thresh_i / above_o.
interface popcount_seq_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = $clog2(DATA_W + 1)
);
    logic              in_valid_i;
    logic              in_ready_o;
    logic [DATA_W-1:0] data_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [CNT_W-1:0]  count_o;
    logic              busy_o;
`ifdef POPCOUNT_SEQ_THRESH_EN
    logic [CNT_W-1:0]  thresh_i;
    logic              above_o;
`endif

    // Requester side
    modport master (
        output in_valid_i,
        output data_i,
        output out_ready_i,
        input  in_ready_o,
        input  out_valid_o,
        input  count_o,
        input  busy_o
`ifdef POPCOUNT_SEQ_THRESH_EN
        ,
        output thresh_i,
        input  above_o
`endif
    );

    // Counter side
    modport slave (
        input  in_valid_i,
        input  data_i,
        input  out_ready_i,
        output in_ready_o,
        output out_valid_o,
        output count_o,
        output busy_o
`ifdef POPCOUNT_SEQ_THRESH_EN
        ,
        input  thresh_i,
        output above_o
`endif
    );
endinterface

// File: rtl/popcount_seq.sv
// popcount_seq: multi-cycle population counter.
// A DATA_W-bit vector is latched, split into WORDLEN-bit chunks, and the
// chunks are counted one per cycle on a single bitcount datapath. The total
// is returned over a valid/ready handshake.
// Optional macro POPCOUNT_SEQ_THRESH_EN adds a combinational count >= thresh
// flag (above_o); counting behaviour is the same in both builds.
module popcount_seq #(
    parameter int DATA_W  = 32,
    parameter int WORDLEN = 7
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    popcount_seq_if.slave bus
);
    localparam int NCHUNK = (DATA_W + WORDLEN - 1) / WORDLEN;
    localparam int CNT_W  = $clog2(DATA_W + 1);
    localparam int IDX_W  = $clog2(NCHUNK + 1);
    localparam int PC_W   = $clog2(WORDLEN + 1);
    localparam int PAD_W  = NCHUNK * WORDLEN;
    // Chunk table is sized to the full index range so any idx value is in bounds
    localparam int NSLOT  = 2 ** IDX_W;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]        state_reg, state_next;
    logic [DATA_W-1:0] data_reg, data_next;
    logic [IDX_W-1:0]  idx_reg, idx_next;
    logic [CNT_W-1:0]  acc_reg, acc_next;
    logic [CNT_W-1:0]  count_reg, count_next;

    logic [PAD_W-1:0]   data_pad;
    logic [WORDLEN-1:0] chunk_arr [NSLOT];
    logic [WORDLEN-1:0] chunk;
    logic [PC_W-1:0]    chunk_cnt;
    logic [CNT_W-1:0]   acc_sum;
    logic               last_chunk;
    logic               accept;
    logic               release_out;

    // Zero-extend the latched vector to a whole number of chunks so padding never counts
    always_comb begin
        data_pad               = '0;
        data_pad[DATA_W-1:0]   = data_reg;
    end

    // Slice the padded vector into chunks; unused slots read as zero
    generate
        for (genvar gi = 0; gi < NSLOT; gi++) begin : g_chunk
            if (gi < NCHUNK) begin : g_real
                assign chunk_arr[gi] = data_pad[gi*WORDLEN +: WORDLEN];
            end else begin : g_zero
                assign chunk_arr[gi] = '0;
            end
        end
    endgenerate

    // Shared bitcount datapath: count the chunk selected by idx and add to acc
    always_comb begin
        chunk     = chunk_arr[idx_reg];
        chunk_cnt = '0;
        for (int b = 0; b < WORDLEN; b++) begin
            chunk_cnt = chunk_cnt + PC_W'(chunk[b]);
        end
        acc_sum = acc_reg + CNT_W'(chunk_cnt);
    end

    assign last_chunk  = (idx_reg == IDX_W'(NCHUNK - 1));
    assign accept      = (state_reg == IDLE) && bus.in_valid_i;
    assign release_out = (state_reg == DONE) && bus.out_ready_i;

    // Next-state logic for IDLE -> RUN -> DONE -> IDLE
    always_comb begin
        state_next = state_reg;
        data_next  = data_reg;
        idx_next   = idx_reg;
        acc_next   = acc_reg;
        count_next = count_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    data_next  = bus.data_i;
                    idx_next   = '0;
                    acc_next   = '0;
                    state_next = RUN;
                end
            end
            RUN: begin
                acc_next = acc_sum;
                idx_next = idx_reg + IDX_W'(1);
                if (last_chunk) begin
                    count_next = acc_sum;
                    state_next = DONE;
                end
            end
            DONE: begin
                // count stays loaded after the handshake until the next job finishes
                if (release_out) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset; reset aborts any job
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_reg <= IDLE;
            data_reg  <= '0;
            idx_reg   <= '0;
            acc_reg   <= '0;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            data_reg  <= data_next;
            idx_reg   <= idx_next;
            acc_reg   <= acc_next;
            count_reg <= count_next;
        end
    end

    assign bus.in_ready_o  = (state_reg == IDLE);
    assign bus.out_valid_o = (state_reg == DONE);
    assign bus.busy_o      = (state_reg != IDLE);
    assign bus.count_o     = count_reg;

`ifdef POPCOUNT_SEQ_THRESH_EN
    // Threshold flag, only meaningful while a result is being offered
    assign bus.above_o = (state_reg == DONE) && (count_reg >= bus.thresh_i);
`endif
endmodule

// File: tb/tb_popcount_seq.sv
// tb_popcount_seq: self-checking bench for popcount_seq (DATA_W=32, WORDLEN=7).
// Reference counts are computed bit-by-bit from the stimulus vector; latency
// expectation is ceil(32/7)=5 cycles. Threshold checks build with
// POPCOUNT_SEQ_THRESH_EN.
module tb_popcount_seq;
    localparam int DATA_W  = 32;
    localparam int WORDLEN = 7;
    localparam int NCHUNK  = (DATA_W + WORDLEN - 1) / WORDLEN;
    localparam int CNT_W   = $clog2(DATA_W + 1);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    popcount_seq_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    popcount_seq #(.DATA_W(DATA_W), .WORDLEN(WORDLEN)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus.slave)
    );

    function automatic int model_count(input logic [31:0] v);
        int c = 0;
        for (int i = 0; i < DATA_W; i++) c += (v[i] ? 1 : 0);
        return c;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer v, wait for acceptance and for the result; data_i is scrambled after accept
    task automatic start_job(input logic [31:0] v, output int lat, output int cnt);
        int guard = 0;
        while (bus.in_ready_o !== 1'b1 && guard < 50) begin
            tick();
            guard++;
        end
        bus.data_i     = v;
        bus.in_valid_i = 1'b1;
        tick();
        bus.in_valid_i = 1'b0;
        bus.data_i     = ~v;
        lat = 0;
        while (bus.out_valid_o !== 1'b1 && lat < 50) begin
            tick();
            lat++;
        end
        cnt = int'(bus.count_o);
        $display("job data=%h count=%0d latency=%0d", v, cnt, lat);
    endtask

    task automatic finish_job();
        bus.out_ready_i = 1'b1;
        tick();
        bus.out_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        n_vec++;
        if (bus.in_ready_o !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready_o); end
        n_vec++;
        if (bus.out_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid_o); end
        n_vec++;
        if (bus.busy_o !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus.busy_o); end
        n_vec++;
        if (bus.count_o !== '0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", bus.count_o); end
`ifdef POPCOUNT_SEQ_THRESH_EN
        n_vec++;
        if (bus.above_o !== 1'b0) begin n_bad++; $display("FAIL reset_above: got %b want 0", bus.above_o); end
`endif
    endtask

    task automatic test_directed();
        logic [31:0] vecs [3] = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h8000_0001};
        int          exps [3] = '{0, 32, 2};
        int lat, cnt;
        for (int i = 0; i < 3; i++) begin
            start_job(vecs[i], lat, cnt);
            n_vec++;
            if (lat != NCHUNK) begin n_bad++; $display("FAIL directed_latency[%0d]: got %0d want %0d", i, lat, NCHUNK); end
            n_vec++;
            if (cnt != exps[i]) begin n_bad++; $display("FAIL directed_count[%0d]: got %0d want %0d", i, cnt, exps[i]); end
            finish_job();
        end
    endtask

    task automatic test_backpressure();
        int lat, cnt;
        start_job(32'h0F0F_0F0F, lat, cnt);
        n_vec++;
        if (lat != NCHUNK) begin n_bad++; $display("FAIL bp_latency: got %0d want %0d", lat, NCHUNK); end
        for (int c = 0; c < 3; c++) begin
            n_vec++;
            if (bus.count_o !== CNT_W'(16) || bus.out_valid_o !== 1'b1 || bus.in_ready_o !== 1'b0 || bus.busy_o !== 1'b1) begin
                n_bad++;
                $display("FAIL bp_hold[%0d]: got count=%0d valid=%b ready=%b busy=%b want 16/1/0/1",
                         c, bus.count_o, bus.out_valid_o, bus.in_ready_o, bus.busy_o);
            end
            tick();
        end
        bus.out_ready_i = 1'b1;
        n_vec++;
        if (bus.in_ready_o !== 1'b0) begin n_bad++; $display("FAIL bp_no_bypass: got in_ready=%b want 0", bus.in_ready_o); end
        tick();
        bus.out_ready_i = 1'b0;
        n_vec++;
        if (bus.in_ready_o !== 1'b1 || bus.out_valid_o !== 1'b0 || bus.busy_o !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_idle: got ready=%b valid=%b busy=%b want 1/0/0", bus.in_ready_o, bus.out_valid_o, bus.busy_o);
        end
        n_vec++;
        if (bus.count_o !== CNT_W'(16)) begin n_bad++; $display("FAIL bp_count_kept: got %0d want 16", bus.count_o); end
    endtask

    task automatic test_reset_mid();
        int lat, cnt;
        bus.data_i     = 32'hFFFF_0000;
        bus.in_valid_i = 1'b1;
        tick();
        bus.in_valid_i = 1'b0;
        n_vec++;
        if (bus.busy_o !== 1'b1 || bus.in_ready_o !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_run_busy: got busy=%b ready=%b want 1/0", bus.busy_o, bus.in_ready_o);
        end
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_vec++;
        if (bus.in_ready_o !== 1'b1 || bus.out_valid_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.count_o !== '0) begin
            n_bad++;
            $display("FAIL mid_reset_state: got ready=%b valid=%b busy=%b count=%0d want 1/0/0/0",
                     bus.in_ready_o, bus.out_valid_o, bus.busy_o, bus.count_o);
        end
        start_job(32'h1234_5678, lat, cnt);
        n_vec++;
        if (lat != NCHUNK || cnt != 13) begin
            n_bad++;
            $display("FAIL mid_reset_newjob: got lat=%0d count=%0d want %0d/13", lat, cnt, NCHUNK);
        end
        finish_job();
    endtask

    task automatic test_back_to_back();
        int lat, cnt;
        logic [31:0] v;
        for (int j = 0; j < 4; j++) begin
            v = $urandom;
            start_job(v, lat, cnt);
            n_vec++;
            if (lat != NCHUNK || cnt != model_count(v)) begin
                n_bad++;
                $display("FAIL b2b_job[%0d]: got lat=%0d count=%0d want %0d/%0d", j, lat, cnt, NCHUNK, model_count(v));
            end
            bus.out_ready_i = 1'b1;
            bus.in_valid_i  = 1'b1;
            bus.data_i      = $urandom;
            n_vec++;
            if (bus.in_ready_o !== 1'b0) begin n_bad++; $display("FAIL b2b_no_bypass[%0d]: got in_ready=%b want 0", j, bus.in_ready_o); end
            tick();
            bus.out_ready_i = 1'b0;
            bus.in_valid_i  = 1'b0;
            n_vec++;
            if (bus.in_ready_o !== 1'b1 || bus.out_valid_o !== 1'b0) begin
                n_bad++;
                $display("FAIL b2b_idle[%0d]: got ready=%b valid=%b want 1/0", j, bus.in_ready_o, bus.out_valid_o);
            end
        end
    endtask

    task automatic test_random();
        int lat, cnt, exp, hold;
        logic [31:0] v;
        for (int j = 0; j < 40; j++) begin
            case ($urandom_range(0, 2))
                0:       v = $urandom;
                1:       v = $urandom & $urandom & $urandom;
                default: v = $urandom | $urandom | $urandom;
            endcase
            exp = model_count(v);
`ifdef POPCOUNT_SEQ_THRESH_EN
            bus.thresh_i = CNT_W'($urandom_range(0, 33));
`endif
            start_job(v, lat, cnt);
            n_vec++;
            if (lat != NCHUNK || cnt != exp) begin
                n_bad++;
                $display("FAIL rand_job[%0d]: data=%h got lat=%0d count=%0d want %0d/%0d", j, v, lat, cnt, NCHUNK, exp);
            end
`ifdef POPCOUNT_SEQ_THRESH_EN
            n_vec++;
            if (bus.above_o !== (exp >= int'(bus.thresh_i))) begin
                n_bad++;
                $display("FAIL rand_above[%0d]: got %b want %b (thresh=%0d)", j, bus.above_o, exp >= int'(bus.thresh_i), bus.thresh_i);
            end
`endif
            hold = $urandom_range(0, 3);
            for (int h = 0; h < hold; h++) begin
                tick();
                n_vec++;
                if (bus.out_valid_o !== 1'b1 || int'(bus.count_o) != exp) begin
                    n_bad++;
                    $display("FAIL rand_hold[%0d]: got valid=%b count=%0d want 1/%0d", j, bus.out_valid_o, bus.count_o, exp);
                end
            end
            finish_job();
        end
    endtask

`ifdef POPCOUNT_SEQ_THRESH_EN
    task automatic test_thresh();
        int lat, cnt;
        bus.thresh_i = CNT_W'(16);
        start_job(32'h0000_FFFF, lat, cnt);
        n_vec++;
        if (bus.above_o !== 1'b1) begin n_bad++; $display("FAIL thresh_ffff: got above=%b want 1", bus.above_o); end
        finish_job();
        n_vec++;
        if (bus.above_o !== 1'b0) begin n_bad++; $display("FAIL thresh_idle: got above=%b want 0", bus.above_o); end
        bus.data_i     = 32'h0000_7FFF;
        bus.in_valid_i = 1'b1;
        tick();
        bus.in_valid_i = 1'b0;
        n_vec++;
        if (bus.above_o !== 1'b0) begin n_bad++; $display("FAIL thresh_run: got above=%b want 0", bus.above_o); end
        lat = 0;
        while (bus.out_valid_o !== 1'b1 && lat < 50) begin tick(); lat++; end
        n_vec++;
        if (bus.out_valid_o !== 1'b1 || bus.count_o !== CNT_W'(15) || bus.above_o !== 1'b0) begin
            n_bad++;
            $display("FAIL thresh_7fff: got valid=%b count=%0d above=%b want 1/15/0", bus.out_valid_o, bus.count_o, bus.above_o);
        end
        finish_job();
    endtask
`endif

    initial begin
        bus.in_valid_i  = 1'b0;
        bus.data_i      = '0;
        bus.out_ready_i = 1'b0;
`ifdef POPCOUNT_SEQ_THRESH_EN
        bus.thresh_i    = '0;
`endif
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_random();
`ifdef POPCOUNT_SEQ_THRESH_EN
        test_thresh();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
